// File: rtl/dec3_8.sv
// dec3_8: registered 3-to-8 one-hot decoder with enable.
// Each output line has its own flop, so every line and vld come straight
// from a register and cannot glitch. An optional build inverts the eight lines.

// One decoded line. It asserts when enabled and the code matches IDX.
module dec3_8_line #(
  parameter int IDX        = 0,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] code,
  output logic       q
);
  localparam logic DEASSERT = ACTIVE_LOW;

  logic hit;

  // Match against this line's index. Enable gates the match.
  always_comb begin
    hit = en && (code == 3'(IDX));
  end

  // Reset wins over the clock. Otherwise register the polarity-adjusted match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= DEASSERT;
    else     q <= hit ? ~DEASSERT : DEASSERT;
  end
endmodule

module dec3_8 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  input  logic b,
  input  logic c,
  output logic i7,
  output logic i6,
  output logic i5,
  output logic i4,
  output logic i3,
  output logic i2,
  output logic i1,
  output logic i0,
  output logic vld
);
  localparam int NUM_LINES = 8;

  logic [2:0]           code;
  logic [NUM_LINES-1:0] line_q;
  logic                 vld_q;

  assign code = {a, b, c};

  // One flop per output line. Line g decodes code g.
  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    dec3_8_line #(
      .IDX        (g),
      .ACTIVE_LOW (OUT_ACTIVE_LOW)
    ) u_line (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .code (code),
      .q    (line_q[g])
    );
  end

  // vld is a registered copy of en. It is never inverted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= en;
  end

  assign {i7, i6, i5, i4, i3, i2, i1, i0} = line_q;
  assign vld = vld_q;
endmodule

// File: tb/tb_dec3_8.sv
// tb_dec3_8: directed scoreboard bench for the default and active-low builds.
// An expected {vld, i7..i0} is queued when stimulus is driven. It is popped
// and compared one edge later against both instances.
module tb_dec3_8;
  logic clk = 1'b0;
  logic rst, en, a, b, c;
  logic h7, h6, h5, h4, h3, h2, h1, h0, hvld;
  logic l7, l6, l5, l4, l3, l2, l1, l0, lvld;

  int n_chk  = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  dec3_8 #(.OUT_ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
    .i7(h7), .i6(h6), .i5(h5), .i4(h4), .i3(h3), .i2(h2), .i1(h1), .i0(h0),
    .vld(hvld)
  );

  dec3_8 #(.OUT_ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c),
    .i7(l7), .i6(l6), .i5(l5), .i4(l4), .i3(l3), .i2(l2), .i1(l1), .i0(l0),
    .vld(lvld)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Compare both builds against an active-high expectation {vld, lines}.
  task automatic chk_both(input string tag, input logic [8:0] e);
    chk({tag, "_hi"}, {hvld, h7, h6, h5, h4, h3, h2, h1, h0}, e);
    chk({tag, "_lo"}, {lvld, l7, l6, l5, l4, l3, l2, l1, l0}, {e[8], ~e[7:0]});
  endtask

  task automatic pop_chk(input string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %b expected entry", tag, {hvld, h7, h6, h5, h4, h3, h2, h1, h0});
    end else begin
      e = exp_q.pop_front();
      chk_both(tag, e);
    end
  endtask

  function automatic logic [8:0] model(input logic e, input logic [2:0] k);
    logic [7:0] one;
    one = 8'(1) << k;
    return {e, e ? one : 8'h00};
  endfunction

  // Drive at the falling edge, then check just after the next rising edge.
  task automatic step(input string tag, input logic e, input logic [2:0] k);
    @(negedge clk);
    en = e;
    {a, b, c} = k;
    exp_q.push_back(model(e, k));
    @(posedge clk);
    #1;
    pop_chk(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; {a, b, c} = 3'b101;
    // Reset is held for two edges with enable and a valid code present.
    repeat (2) @(posedge clk);
    #1;
    chk_both("reset_hold", 9'h000);

    // Sweep all codes back to back.
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 8; k++) step($sformatf("sweep%0d", k), 1'b1, 3'(k));

    // Enable low clears the lines. Enable high again decodes the held code.
    step("en_low", 1'b0, 3'b011);
    step("en_back", 1'b1, 3'b011);

    // Mid-stream reset while code 100 is on the outputs.
    for (int k = 0; k < 5; k++) step($sformatf("pre_rst%0d", k), 1'b1, 3'(k));
    #2; rst = 1'b1;
    #1; chk_both("async_clear", 9'h000);
    {a, b, c} = 3'b110;
    @(posedge clk); #1;
    chk_both("rst_ignores_edge", 9'h000);
    @(negedge clk); rst = 1'b0;
    step("resume", 1'b1, 3'b111);
    step("resume2", 1'b1, 3'b110);

    // Between-edge stability. Only the value present at the edge counts.
    @(negedge clk);
    en = 1'b1; {a, b, c} = 3'b010;
    #1 {a, b, c} = 3'b111;
    #1 {a, b, c} = 3'b000;
    #1 {a, b, c} = 3'b001;
    exp_q.push_back(model(1'b1, 3'b001));
    @(posedge clk); #1;
    pop_chk("stable_edge");
    {a, b, c} = 3'b100; en = 1'b0;
    #2 chk_both("stable_mid1", model(1'b1, 3'b001));
    {a, b, c} = 3'b111; en = 1'b1;
    #3 chk_both("stable_mid2", model(1'b1, 3'b001));

    step("final_dis", 1'b0, 3'b000);

    n_chk++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Backstop so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
